// File: rtl/lcd_vga_scan_if.sv
// lcd_vga_scan_if: scan-out bundle between the frame-buffer writer, the pixel-rate source and the VGA sink.
//   pix_ce  : pixel clock enable (master -> slave)
//   lcdon   : LCD enable, low blanks the image to BG (master -> slave)
//   vram_a  : frame-buffer write address {line[5:0], nibble[7:0]} (master -> slave)
//   vram_do : frame-buffer write nibble, bit3 is the leftmost pixel (master -> slave)
//   vram_we : frame-buffer write strobe (master -> slave)
//   hsync_n, vsync_n, de, rgb : registered VGA pixel stream (slave -> master)
interface lcd_vga_scan_if;
   logic        pix_ce;
   logic        lcdon;
   logic [13:0] vram_a;
   logic [3:0]  vram_do;
   logic        vram_we;
   logic        hsync_n;
   logic        vsync_n;
   logic        de;
   logic [11:0] rgb;
   modport master(output pix_ce, lcdon, vram_a, vram_do, vram_we, input hsync_n, vsync_n, de, rgb);
   modport slave(input pix_ce, lcdon, vram_a, vram_do, vram_we, output hsync_n, vsync_n, de, rgb);
endinterface

// File: rtl/lcd_vga_scan.sv
// lcd_vga_scan: 64x256-nibble 1bpp frame buffer scanned out as a VGA-timed RGB444 pixel stream.
//   mck : system clock
//   rin : synchronous active-high reset
//   bus : lcd_vga_scan_if.slave (pix_ce, lcdon, vram_a/vram_do/vram_we in; hsync_n, vsync_n, de, rgb out)
// Optional macro SCANLINE_EN: blank the last output line of every V_SCALE group inside the image window.
module lcd_vga_scan #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          V_SCALE  = 4,
   parameter int          V_OFFSET = 112,
   parameter logic [11:0] FG       = 12'h000,
   parameter logic [11:0] BG       = 12'hCDB
) (
   input logic          mck,
   input logic          rin,
   lcd_vga_scan_if.slave bus
);
   localparam int VS_SH = $clog2(V_SCALE);
   localparam logic [9:0] HA  = 10'(H_ACTIVE);
   localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VA  = 10'(V_ACTIVE);
   localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VO  = 10'(V_OFFSET);
   localparam logic [9:0] VE  = 10'(V_OFFSET + 64 * V_SCALE);
   localparam logic [9:0] VM  = 10'(V_SCALE - 1);
   logic [3:0] mem [0:16383];
   logic [9:0] hcnt, vcnt, voff;
   logic [5:0] zline;
   logic [3:0] rd_q, nib_q, nib;
   logic       ce_d, act, win, pix, gap;
   always_comb begin
      voff  = vcnt - VO;
      zline = 6'(voff >> VS_SH);
      act   = hcnt < HA && vcnt < VA;
      win   = vcnt >= VO && vcnt < VE;
      // first pixel of a nibble comes straight from the fresh read, the rest from the held copy
      nib   = hcnt[1:0] == 2'd0 ? rd_q : nib_q;
      pix   = nib[~hcnt[1:0]];
`ifdef SCANLINE_EN
      gap   = (voff & VM) == VM;
`else
      gap   = 1'b0;
`endif
   end
   // read-first RAM; one read per pixel, issued the mck after pix_ce moved the counters
   always_ff @(posedge mck) begin
      if (bus.vram_we) mem[bus.vram_a] <= bus.vram_do;
      if (ce_d) rd_q <= mem[{zline, hcnt[9:2]}];
   end
   always_ff @(posedge mck) begin
      if (rin) begin
         hcnt        <= '0;
         vcnt        <= '0;
         ce_d        <= 1'b1;
         nib_q       <= '0;
         bus.hsync_n <= 1'b1;
         bus.vsync_n <= 1'b1;
         bus.de      <= 1'b0;
         bus.rgb     <= BG;
      end else begin
         ce_d <= bus.pix_ce;
         if (bus.pix_ce) begin
            hcnt <= hcnt == HL ? '0 : hcnt + 10'd1;
            if (hcnt == HL) vcnt <= vcnt == VL ? '0 : vcnt + 10'd1;
            if (hcnt[1:0] == 2'd0) nib_q <= rd_q;
            bus.hsync_n <= !(hcnt >= HS0 && hcnt < HS1);
            bus.vsync_n <= !(vcnt >= VS0 && vcnt < VS1);
            bus.de      <= act;
            bus.rgb     <= !act ? 12'h000 : (bus.lcdon && win && pix && !gap) ? FG : BG;
         end
      end
   end
endmodule

// File: tb/tb_lcd_vga_scan.sv
// tb_lcd_vga_scan: checks lcd_vga_scan against a pixel-position reference model.
// A shrunken-timing instance (dut) covers whole frames and the image window; a default-timing
// instance (dut_full) shares every input and covers the first lines of the standard 800x525 raster.
module tb_lcd_vga_scan;
   localparam logic [11:0] FG = 12'h000;
   localparam logic [11:0] BG = 12'hCDB;
   localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
   localparam int SVA = 136, SVF = 3, SVS = 2, SVB = 3, SSC = 2, SOFF = 4;
   localparam int SHT = 24, SVT = 144, SFR = SHT * SVT;
   logic mck = 1'b0;
   logic rin = 1'b1;
   always #5 mck = ~mck;
   lcd_vga_scan_if bs();
   lcd_vga_scan_if bf();
   assign bf.pix_ce  = bs.pix_ce;
   assign bf.lcdon   = bs.lcdon;
   assign bf.vram_a  = bs.vram_a;
   assign bf.vram_do = bs.vram_do;
   assign bf.vram_we = bs.vram_we;
   lcd_vga_scan #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB), .V_ACTIVE(SVA), .V_FP(SVF),
                  .V_SYNC(SVS), .V_BP(SVB), .V_SCALE(SSC), .V_OFFSET(SOFF), .FG(FG), .BG(BG))
      dut (.mck(mck), .rin(rin), .bus(bs.slave));
   lcd_vga_scan dut_full (.mck(mck), .rin(rin), .bus(bf.slave));
   logic [3:0]  mm [0:16383];
   logic [11:0] fr [SVT][SHT];
   logic [14:0] got_s, got_f, exp_s, exp_f;
   int errors = 0, checks = 0, p = 0;
   // expected {hsync_n, vsync_n, de, rgb} for raster position p under the given timing
   function automatic logic [14:0] ref_out(input int pp, ha, hf, hs, hb, va, vf, vs, vb, sc, off,
                                           input logic lcd);
      int h, v, z;
      logic act, win, px;
      logic [3:0] n;
      h = pp % (ha + hf + hs + hb);
      v = (pp / (ha + hf + hs + hb)) % (va + vf + vs + vb);
      act = h < ha && v < va;
      win = v >= off && v < off + 64 * sc;
      px = 1'b0;
      if (act && win) begin
         z = (v - off) / sc;
         n = mm[z * 256 + h / 4];
         px = n[2'(3 - h % 4)];
`ifdef SCANLINE_EN
         if ((v - off) % sc == sc - 1) px = 1'b0;
`endif
      end
      return {!(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs), act,
              !act ? 12'h000 : (lcd && px) ? FG : BG};
   endfunction
   task automatic tick();
      repeat ($urandom_range(0, 3) == 0 ? 2 : 1) @(negedge mck);
      bs.pix_ce = 1'b1;
      @(negedge mck);
      bs.pix_ce = 1'b0;
      got_s = {bs.hsync_n, bs.vsync_n, bs.de, bs.rgb};
      got_f = {bf.hsync_n, bf.vsync_n, bf.de, bf.rgb};
      exp_s = ref_out(p, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SSC, SOFF, bs.lcdon);
      exp_f = ref_out(p, 640, 16, 96, 48, 480, 10, 2, 33, 4, 112, bs.lcdon);
      p++;
   endtask
   task automatic wr(input logic [13:0] a, input logic [3:0] d);
      bs.vram_a = a;
      bs.vram_do = d;
      bs.vram_we = 1'b1;
      mm[a] = d;
      @(negedge mck);
      bs.vram_we = 1'b0;
   endtask
   task automatic test_reset();
      repeat (3) @(negedge mck);
      checks++;
      if ({bs.hsync_n, bs.vsync_n, bs.de} !== 3'b110) begin
         errors++;
         $display("FAIL reset_sync_de: got %b want 110", {bs.hsync_n, bs.vsync_n, bs.de});
      end
      checks++;
      if (bs.rgb !== BG) begin errors++; $display("FAIL reset_rgb: got %h want %h", bs.rgb, BG); end
      checks++;
      if ({bf.hsync_n, bf.vsync_n, bf.de, bf.rgb} !== {3'b110, BG}) begin
         errors++;
         $display("FAIL reset_full: got %h want %h", {bf.hsync_n, bf.vsync_n, bf.de, bf.rgb}, {3'b110, BG});
      end
      rin = 1'b0;
      p = 0;
      for (int l = 0; l < 64; l++) for (int n = 0; n < 4; n++) wr({6'(l), 8'(n)}, 4'h0);
   endtask
   task automatic test_timing();
      int bad = 0, badp = -1, q, hsn = 0, hsf = -1, vsn = 0, vsf = -1, den = 0, fg = 0;
      int fhsn = 0, fhsf = -1, fden = 0;
      logic [47:0] want;
      wr(14'h0000, 4'b1000);
      wr({6'd63, 8'd3}, 4'b0101);
      wr({6'd0, 8'd200}, 4'hF);
      wr({6'd10, 8'd4}, 4'hF);
      for (int i = 0; i < SFR; i++) begin
         tick();
         q = p - 1;
         if (got_s !== exp_s || got_f !== exp_f) begin if (bad == 0) badp = q; bad++; end
         fr[q / SHT][q % SHT] = got_s[11:0];
         if (!got_s[14]) begin hsn++; if (hsf < 0) hsf = q; end
         if (!got_s[13]) begin vsn++; if (vsf < 0) vsf = q; end
         if (got_s[12]) den++;
         if (got_s[12] && got_s[11:0] == FG) fg++;
         if (!got_f[14]) begin fhsn++; if (fhsf < 0) fhsf = q; end
         if (got_f[12]) fden++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL timing_model: %0d mismatches first at p=%0d, want 0", bad, badp); end
      checks++;
      if (hsn !== 432) begin errors++; $display("FAIL hsync_count: got %0d want 432", hsn); end
      checks++;
      if (hsf !== 18) begin errors++; $display("FAIL hsync_start: got %0d want 18", hsf); end
      checks++;
      if (vsn !== 48) begin errors++; $display("FAIL vsync_count: got %0d want 48", vsn); end
      checks++;
      if (vsf !== 3336) begin errors++; $display("FAIL vsync_start: got %0d want 3336", vsf); end
      checks++;
      if (den !== 2176) begin errors++; $display("FAIL de_count: got %0d want 2176", den); end
      checks++;
      if (fhsn !== 384) begin errors++; $display("FAIL full_hsync_count: got %0d want 384", fhsn); end
      checks++;
      if (fhsf !== 656) begin errors++; $display("FAIL full_hsync_start: got %0d want 656", fhsf); end
      checks++;
      if (fden !== 2816) begin errors++; $display("FAIL full_de_count: got %0d want 2816", fden); end
      checks++;
      if ({fr[3][0], fr[4][0], fr[6][0]} !== {BG, FG, BG}) begin
         errors++;
         $display("FAIL line0_pix0: got %h want %h", {fr[3][0], fr[4][0], fr[6][0]}, {BG, FG, BG});
      end
`ifdef SCANLINE_EN
      want = {BG, BG, BG, BG};
`else
      want = {BG, FG, BG, FG};
`endif
      checks++;
      if (fr[5][0] !== want[35:24]) begin errors++; $display("FAIL line0_repeat: got %h want %h", fr[5][0], want[35:24]); end
      checks++;
      if ({fr[130][12], fr[130][13], fr[130][14], fr[130][15]} !== {BG, FG, BG, FG}) begin
         errors++;
         $display("FAIL line63_last: got %h want %h", {fr[130][12], fr[130][13], fr[130][14], fr[130][15]}, {BG, FG, BG, FG});
      end
      checks++;
      if ({fr[131][12], fr[131][13], fr[131][14], fr[131][15]} !== want) begin
         errors++;
         $display("FAIL line63_repeat: got %h want %h", {fr[131][12], fr[131][13], fr[131][14], fr[131][15]}, want);
      end
      checks++;
`ifdef SCANLINE_EN
      if (fg !== 3) begin errors++; $display("FAIL fg_count: got %0d want 3", fg); end
`else
      if (fg !== 6) begin errors++; $display("FAIL fg_count: got %0d want 6", fg); end
`endif
   endtask
   task automatic test_lcdon();
      int bad = 0, fg = 0, den = 0, hsn = 0;
      for (int l = 0; l < 64; l++) wr({6'(l), 8'($urandom_range(0, 3))}, 4'hF);
      bs.lcdon = 1'b0;
      for (int i = 0; i < SFR; i++) begin
         tick();
         if (got_s !== exp_s || got_f !== exp_f) bad++;
         if (got_s[12] && got_s[11:0] == FG) fg++;
         if (got_s[12]) den++;
         if (!got_s[14]) hsn++;
      end
      bs.lcdon = 1'b1;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL lcdon_model: got %0d mismatches want 0", bad); end
      checks++;
      if (fg !== 0) begin errors++; $display("FAIL lcdon_fg: got %0d want 0", fg); end
      checks++;
      if (den !== 2176 || hsn !== 432) begin
         errors++;
         $display("FAIL lcdon_timing: got de=%0d hs=%0d want de=2176 hs=432", den, hsn);
      end
   endtask
   task automatic test_random_image();
      int bad = 0, fg = 0;
      for (int i = 0; i < 96; i++)
         wr({6'($urandom_range(0, 63)), 8'($urandom_range(0, 5))}, 4'($urandom));
      for (int i = 0; i < SFR; i++) begin
         tick();
         if (got_s !== exp_s || got_f !== exp_f) bad++;
         if (got_s[12] && got_s[11:0] == FG) fg++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL random_model: got %0d mismatches want 0 (fg=%0d)", bad, fg); end
   endtask
   task automatic test_collision();
      int bad = 0;
      logic [11:0] r [4];
      wr(14'd1, 4'b1010);
      while (p % SFR != 4 * SHT + 4) begin tick(); if (got_s !== exp_s || got_f !== exp_f) bad++; end
      // this write lands on the same mck as the read of line 0 nibble 1
      wr(14'd1, 4'b0101);
      mm[1] = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         r[k] = got_s[11:0];
         if (got_s !== exp_s || got_f !== exp_f) bad++;
      end
      mm[1] = 4'b0101;
      checks++;
      if ({r[0], r[1], r[2], r[3]} !== {FG, BG, FG, BG}) begin
         errors++;
         $display("FAIL collision_old: got %h want %h", {r[0], r[1], r[2], r[3]}, {FG, BG, FG, BG});
      end
      while (p % SFR != 4 * SHT + 4) begin tick(); if (got_s !== exp_s || got_f !== exp_f) bad++; end
      for (int k = 0; k < 4; k++) begin
         tick();
         r[k] = got_s[11:0];
         if (got_s !== exp_s || got_f !== exp_f) bad++;
      end
      checks++;
      if ({r[0], r[1], r[2], r[3]} !== {BG, FG, BG, FG}) begin
         errors++;
         $display("FAIL collision_new: got %h want %h", {r[0], r[1], r[2], r[3]}, {BG, FG, BG, FG});
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL collision_model: got %0d mismatches want 0", bad); end
   endtask
   task automatic test_reset_midline();
      int bad = 0;
      while (p % 800 != 300) begin tick(); if (got_s !== exp_s || got_f !== exp_f) bad++; end
      rin = 1'b1;
      @(negedge mck);
      checks++;
      if ({bf.hsync_n, bf.vsync_n, bf.de, bf.rgb} !== {3'b110, BG}) begin
         errors++;
         $display("FAIL midline_reset_full: got %h want %h", {bf.hsync_n, bf.vsync_n, bf.de, bf.rgb}, {3'b110, BG});
      end
      checks++;
      if ({bs.hsync_n, bs.vsync_n, bs.de, bs.rgb} !== {3'b110, BG}) begin
         errors++;
         $display("FAIL midline_reset: got %h want %h", {bs.hsync_n, bs.vsync_n, bs.de, bs.rgb}, {3'b110, BG});
      end
      rin = 1'b0;
      p = 0;
      tick();
      checks++;
      if (got_s !== exp_s || got_f !== exp_f) begin
         errors++;
         $display("FAIL restart_pos0: got %h/%h want %h/%h", got_s, got_f, exp_s, exp_f);
      end
      for (int i = 1; i < SFR; i++) begin tick(); if (got_s !== exp_s || got_f !== exp_f) bad++; end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL restart_model: got %0d mismatches want 0", bad); end
   endtask
   initial begin
      bs.pix_ce = 1'b0;
      bs.lcdon = 1'b1;
      bs.vram_a = '0;
      bs.vram_do = '0;
      bs.vram_we = 1'b0;
      for (int i = 0; i < 16384; i++) mm[i] = 4'h0;
      test_reset();
      test_timing();
      test_lcdon();
      test_random_image();
      test_collision();
      test_reset_midline();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
